ldpc_llr_framer: RTL and testbench



---
 rtl/ldpc_llr_framer.sv | 205 ++++++++++++++++++++
 tb/tb_ldpc_llr_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_llr_framer.sv
// Soft-sample to LLR converter with ping-pong frame buffer feeding ldpc_decoder.
// Define LDPC_LLR_FRAMER_STATS_EN to build the emitted-frame counter on o_frame_count.
module ldpc_llr_framer #(
    parameter int WIDTH     = 16,
    parameter int LLR_WIDTH = 8,
    parameter int FRAME_LEN = 64,
    parameter int SHIFT     = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    input  logic             i_in_sof,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_out_sof,
    output logic             o_out_eof,
    output logic             o_overflow,
    output logic             o_sync_err,
    output logic [15:0]      o_frame_count
);
    // state | meaning
    // IDLE  | no frame being read; waits for full[rd_bank]
    // READ  | issuing one buffered word per cycle from rd_bank
    typedef enum logic {IDLE, READ} state_t;

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic signed [WIDTH:0] SAT_MAX = (WIDTH+1)'((1 << (LLR_WIDTH - 1)) - 1);
    localparam logic signed [WIDTH:0] SAT_MIN = -SAT_MAX;

    logic signed [WIDTH:0] x_ext;
    logic signed [WIDTH:0] t_shift;
    logic signed [WIDTH:0] t_sat;

    logic             s1_valid;
    logic             s1_sof;
    logic [WIDTH-1:0] s1_data;

    logic [WIDTH-1:0] mem [2][FRAME_LEN];
    logic [1:0]       full;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] wr_addr;
    logic             wr_en;
    logic             wr_done;
    logic             drop;
    logic             resync;

    state_t           state;
    state_t           state_next;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_fire;
    logic             rd_last;
    logic             next_ready;
    logic             rd_v;
    logic             rd_sof;
    logic             rd_eof;
    logic [WIDTH-1:0] rd_q;

    // Stage 1: round-half-up shift at WIDTH+1 bits, then symmetric saturation
    assign x_ext = {i_in_data[WIDTH-1], i_in_data};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [WIDTH:0] RND = (WIDTH+1)'(1 << (SHIFT - 1));
            assign t_shift = (x_ext + RND) >>> SHIFT;
        end else begin : g_pass
            assign t_shift = x_ext;
        end
    endgenerate

    always_comb begin
        t_sat = t_shift;
        if (t_shift > SAT_MAX)
            t_sat = SAT_MAX;
        else if (t_shift < SAT_MIN)
            t_sat = SAT_MIN;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= i_in_valid;
            s1_sof   <= i_in_valid & i_in_sof;
            s1_data  <= i_in_valid ? WIDTH'(t_sat) : '0;
        end
    end

    // Stage 2: write side. A full target bank wins over a resync request.
    always_comb begin
        drop    = s1_valid && full[wr_bank];
        wr_en   = s1_valid && !full[wr_bank];
        resync  = wr_en && s1_sof && (wr_idx != '0);
        wr_addr = resync ? '0 : wr_idx;
        wr_done = wr_en && (wr_addr == LAST_IDX);
    end

    always_ff @(posedge i_clock) begin
        if (wr_en)
            mem[wr_bank][wr_addr] <= s1_data;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            full       <= 2'b00;
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            o_overflow <= 1'b0;
            o_sync_err <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_done) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_addr + 1'b1;
                end
            end
            if (drop)
                o_overflow <= 1'b1;
            if (resync)
                o_sync_err <= 1'b1;
            // set and clear always target different banks
            if (wr_done)
                full[wr_bank] <= 1'b1;
            if (rd_last)
                full[rd_bank] <= 1'b0;
        end
    end

    // Read FSM. The continue decision looks ahead at a frame completing this
    // cycle so back-to-back frames stream without a gap.
    always_comb begin
        state_next = state;
        rd_fire    = 1'b0;
        rd_last    = 1'b0;
        next_ready = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    rd_fire    = 1'b1;
                    state_next = READ;
                end
            end
            READ: rd_fire = 1'b1;
            default: state_next = IDLE;
        endcase
        if (rd_fire && (rd_idx == LAST_IDX)) begin
            rd_last = 1'b1;
            if (!next_ready)
                state_next = IDLE;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_idx      <= '0;
            rd_v        <= 1'b0;
            rd_sof      <= 1'b0;
            rd_eof      <= 1'b0;
            rd_q        <= '0;
            o_out_valid <= 1'b0;
            o_out_sof   <= 1'b0;
            o_out_eof   <= 1'b0;
            o_out_data  <= '0;
        end else begin
            state  <= state_next;
            rd_v   <= rd_fire;
            rd_sof <= rd_fire && (rd_idx == '0);
            rd_eof <= rd_last;
            rd_q   <= rd_fire ? mem[rd_bank][rd_idx] : '0;
            if (rd_fire)
                rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
            if (rd_last)
                rd_bank <= ~rd_bank;
            o_out_valid <= rd_v;
            o_out_sof   <= rd_sof;
            o_out_eof   <= rd_eof;
            o_out_data  <= rd_q;
        end
    end

`ifdef LDPC_LLR_FRAMER_STATS_EN
    logic [15:0] frame_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            frame_count <= 16'd0;
        else if (rd_eof)
            frame_count <= frame_count + 16'd1;
    end

    assign o_frame_count = frame_count;
`else
    assign o_frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_ldpc_llr_framer.sv
// Directed bench for ldpc_llr_framer: conversion, framing, back-to-back streaming, resync and reset.
module tb_ldpc_llr_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [15:0] out_data;
    logic        out_valid, out_sof, out_eof, overflow, sync_err;
    logic [15:0] frame_count;

`ifdef LDPC_LLR_FRAMER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    always #5 clk = ~clk;

    ldpc_llr_framer #(.WIDTH(16), .LLR_WIDTH(8), .FRAME_LEN(64), .SHIFT(4)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_in_data(in_data), .i_in_valid(in_valid), .i_in_sof(in_sof),
        .o_out_data(out_data), .o_out_valid(out_valid), .o_out_sof(out_sof), .o_out_eof(out_eof),
        .o_overflow(overflow), .o_sync_err(sync_err), .o_frame_count(frame_count)
    );

    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        e;
        int          c;
    } word_t;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          idle_bad = 0;
    int          last_c;
    int          n_seen;
    word_t       wq[$];
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // output logger: every valid word with its cycle stamp
    always @(negedge clk) begin
        if (out_valid === 1'b1)
            wq.push_back('{out_data, out_sof, out_eof, cyc});
        else if (out_data !== 16'h0 || out_sof !== 1'b0 || out_eof !== 1'b0)
            idle_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_words(input string tag, input int first_c);
        chk({tag, " count"}, wq.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wq.size(); k++) begin
            chk($sformatf("%s data[%0d]", tag, k), wq[k].d, exp_q[k]);
            chk($sformatf("%s sof[%0d]", tag, k), wq[k].s, (k % 64) == 0);
            chk($sformatf("%s eof[%0d]", tag, k), wq[k].e, (k % 64) == 63);
            if (k > 0)
                chk($sformatf("%s gap[%0d]", tag, k), wq[k].c, wq[k-1].c + 1);
        end
        if (first_c >= 0 && wq.size() > 0)
            chk({tag, " latency"}, wq[0].c, first_c);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " valid"}, out_valid, 1'b0);
        chk({tag, " data"}, out_data, 16'h0);
        chk({tag, " sof"}, out_sof, 1'b0);
        chk({tag, " eof"}, out_eof, 1'b0);
        chk({tag, " overflow"}, overflow, 1'b0);
        chk({tag, " sync_err"}, sync_err, 1'b0);
        chk({tag, " frame_count"}, frame_count, 16'h0);
    endtask

    initial begin
        // reset and long idle
        idle(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        idle(1000);
        chk("idle words", wq.size(), 0);
        chk("idle overflow", overflow, 1'b0);
        chk("idle sync_err", sync_err, 1'b0);

        // one frame of 0x0100 -> 0x0010
        wq.delete(); exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(16'h0010);
            drive(16'h0100, k == 0);
        end
        last_c = cyc;
        idle(80);
        chk_words("frame1", last_c + 3);
        chk("frame1 count", frame_count, 16'(STATS * 1));

        // saturation and rounding corners
        wq.delete(); exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            case (k)
                0: begin drive(16'h7FFF, 1'b1); exp_q.push_back(16'h007F); end
                1: begin drive(16'h8000, 1'b0); exp_q.push_back(16'hFF81); end
                2: begin drive(16'd24, 1'b0);   exp_q.push_back(16'h0002); end
                3: begin drive(16'hFFE8, 1'b0); exp_q.push_back(16'hFFFF); end
                default: begin drive(16'(k * 16), 1'b0); exp_q.push_back(16'(k)); end
            endcase
        end
        last_c = cyc;
        idle(80);
        chk_words("corners", last_c + 3);
        chk("corners count", frame_count, 16'(STATS * 2));

        // three frames back-to-back plus a 10-sample partial
        wq.delete(); exp_q.delete();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 64; k++) begin
                exp_q.push_back(16'(f * 64 + k - 96));
                drive(16'((f * 64 + k - 96) * 16), k == 0);
            end
        for (int j = 0; j < 10; j++)
            drive(16'(j * 16), j == 0);
        idle(300);
        chk_words("b2b", -1);
        chk("b2b overflow", overflow, 1'b0);
        chk("b2b sync_err", sync_err, 1'b0);
        chk("b2b count", frame_count, 16'(STATS * 5));

        // complete the retained partial frame
        wq.delete(); exp_q.delete();
        for (int j = 0; j < 64; j++)
            exp_q.push_back(16'(j));
        for (int j = 10; j < 64; j++)
            drive(16'(j * 16), 1'b0);
        last_c = cyc;
        idle(80);
        chk_words("partial", last_c + 3);
        chk("partial count", frame_count, 16'(STATS * 6));

        // sof arriving at sample 20 restarts the frame
        wq.delete(); exp_q.delete();
        for (int k = 0; k < 20; k++)
            drive(16'h7FFF, k == 0);
        for (int j = 0; j < 64; j++) begin
            exp_q.push_back(16'(j));
            drive(16'(j * 16), j == 0);
        end
        last_c = cyc;
        idle(80);
        chk_words("resync", last_c + 3);
        chk("resync sync_err", sync_err, 1'b1);
        chk("resync overflow", overflow, 1'b0);
        chk("resync count", frame_count, 16'(STATS * 7));

        // reset in the middle of a burst
        wq.delete(); exp_q.delete();
        for (int j = 0; j < 64; j++)
            drive(16'(j * 16), j == 0);
        for (int i = 0; i < 100 && wq.size() < 30; i++)
            @(negedge clk);
        chk("midreset reached word 30", wq.size() >= 30, 1'b1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        n_seen = wq.size();
        idle(3);
        rst = 1'b0;
        idle(200);
        chk("midreset no words", wq.size(), n_seen);

        // fresh frame after reset
        wq.delete(); exp_q.delete();
        for (int j = 0; j < 64; j++) begin
            exp_q.push_back(16'(63 - j));
            drive(16'((63 - j) * 16), j == 0);
        end
        last_c = cyc;
        idle(80);
        chk_words("post reset", last_c + 3);
        chk("post reset count", frame_count, 16'(STATS * 1));
        chk("idle data zero", idle_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
